hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the five-stage core. Compares ID-stage source registers against EX/MEM destinations, tracks branch redirects and multi-cycle mul/div occupancy, and drives the stall (`data_hazard`) and flush (`control_hazard`) inputs of the IF/ID register. It also drives the PC-hold, ID/EX-bubble and EX-hold controls. A small FSM sequences multi-cycle redirect flushes and mul/div waits; per-cycle decisions are combinational from FSM state plus stage inputs.

## Interface
- `FLUSH_CYCLES`, 1, cycles `control_hazard` stays high per taken redirect, range 1–7; covers IMEM fetch latency.
- `clk` in 1 — single clock, rising edge.
- `rst` in 1 — synchronous, active-low reset; sampled on `clk` rising edge.
- `id_rs1`, `id_rs2` in 5 — ID-stage source register numbers.
- `id_rs1_used`, `id_rs2_used` in 1 — ID instruction actually reads rs1/rs2.
- `ex_rd` in 5 — EX destination register.
- `ex_reg_write` in 1 — EX instruction writes `ex_rd`.
- `ex_mem_read` in 1 — EX instruction is a load.
- `mem_rd` in 5 — MEM destination register.
- `mem_reg_write` in 1 — MEM instruction writes `mem_rd`.
- `ex_branch_taken` in 1 — EX resolved a taken branch or jump; PC redirect this cycle.
- `ex_md_start` in 1 — mul/div op entered EX this cycle.
- `md_done` in 1 — mul/div result valid this cycle.
- `pc_stall` out 1 — hold PC.
- `data_hazard` out 1 — hold IF/ID.
- `control_hazard` out 1 — clear IF/ID to zero (nop).
- `id_ex_flush` out 1 — load bubble into ID/EX.
- `ex_stall` out 1 — hold ID/EX and EX; EX/MEM loads a bubble.
- `hz_state` out 2 — FSM state: 0 RUN, 1 REDIRECT, 2 MD_WAIT.

## Operation
- **States:** RUN, REDIRECT, MD_WAIT. `flush_cnt` is 3 bits.
- **RAW match:** `(id_rsN_used && id_rsN == X && X != 0)`. Register x0 never hazards.
- **Priority each cycle:** redirect > mul/div > data stall.
- **RUN, `ex_branch_taken`=1:**
  - Assert `control_hazard` and `id_ex_flush`.
  - Data stall suppressed; mul/div start ignored.
  - If `FLUSH_CYCLES`>1, go to REDIRECT with `flush_cnt`=`FLUSH_CYCLES`-1; else stay RUN.
- **REDIRECT:**
  - Assert `control_hazard` only.
  - Decrement `flush_cnt`; return to RUN after the cycle where `flush_cnt`==1.
  - `ex_branch_taken` here reloads `flush_cnt`=`FLUSH_CYCLES`-1 and asserts `id_ex_flush`.
- **RUN, `ex_md_start`=1, no redirect:**
  - If `md_done`=1 the same cycle, no stall.
  - Else assert `pc_stall`, `data_hazard`, `ex_stall`, and go to MD_WAIT.
- **MD_WAIT:**
  - Assert `pc_stall`, `data_hazard`, `ex_stall` while `md_done`=0.
  - The `md_done` cycle asserts no stalls; return to RUN.
  - `ex_branch_taken`, `ex_md_start` and data stall are ignored.
- **RUN data stall:** assert `pc_stall`, `data_hazard`, `id_ex_flush`. Stall conditions:
  - Load-use: RAW vs `ex_rd` with `ex_mem_read`.
  - Plus, per Configuration, RAW vs EX/MEM writers.
- **Invariant:** `control_hazard` and `data_hazard` are never both 1.
- **Reset:**
  - rst=0 forces RUN and `flush_cnt`=0; all outputs 0 and `hz_state`=0 in the reset cycle.
  - Reset mid-REDIRECT or mid-MD_WAIT abandons the sequence.

## Timing
- All hazard outputs are combinational: asserted in the same cycle as the triggering input.
- State and `flush_cnt` update on `clk` rising edge.
- **Load-use:** exactly 1 stall cycle, because the bubble clears the EX match.
- **Redirect:** `control_hazard` high for exactly `FLUSH_CYCLES` consecutive cycles.
- **Mul/div:** stall covers the `ex_md_start` cycle through the cycle before `md_done`.
- Register file is write-before-read, so WB needs no stall.

## Configuration
- `HAZARD_FWD_EN` defined: forwarding exists; the only data stall is load-use.
- Undefined: data stall also on RAW vs EX (`ex_reg_write`) or vs MEM (`mem_reg_write`). This yields 2 stall cycles for a back-to-back dependency and 1 for distance-2.
- `mem_rd`/`mem_reg_write` are unused when `HAZARD_FWD_EN` is defined.

## Test plan
- **Load-use:** `ex_mem_read`=1, `ex_rd`=5, `id_rs1`=5 used.
  - Expect `pc_stall`=`data_hazard`=`id_ex_flush`=1 for one cycle.
  - Same with `ex_rd`=0 → no stall.
- **Redirect:** `FLUSH_CYCLES`=3, pulse `ex_branch_taken` in RUN.
  - Expect `control_hazard`=1 for 3 cycles, `id_ex_flush` only the first cycle.
  - Expect `hz_state` sequence 0,1,1,0.
- **Simultaneous:** `ex_branch_taken`=1 with a load-use match → `control_hazard`=1, `data_hazard`=0.
- **Mul/div:** `ex_md_start`, `md_done` after 4 cycles.
  - Expect `ex_stall`=1 for 4 cycles, 0 on the `md_done` cycle.
  - Expect `hz_state` 2 during the wait.
  - Also test `ex_md_start` with `md_done` in the same cycle → no stall.
- **No forwarding** (macro undefined): `ex_rd`=7 written, `id_rs2`=7 used → stall; next cycle with `mem_rd`=7 → stall; then release.
  - Macro defined: same stimulus → no stall.
- **Reset mid-MD_WAIT:** drive rst=0 for one cycle → all outputs 0, `hz_state`=0; RUN resumes next cycle.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: RAW/load-use stalls, redirect flush sequencing and mul/div waits.
// Optional build macro HAZARD_FWD_EN: forwarding present, so the only data stall is load-use.
module hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_rs1_used,
    input  logic       id_rs2_used,
    input  logic [4:0] ex_rd,
    input  logic       ex_reg_write,
    input  logic       ex_mem_read,
    input  logic [4:0] mem_rd,
    input  logic       mem_reg_write,
    input  logic       ex_branch_taken,
    input  logic       ex_md_start,
    input  logic       md_done,
    output logic       pc_stall,
    output logic       data_hazard,
    output logic       control_hazard,
    output logic       id_ex_flush,
    output logic       ex_stall,
    output logic [1:0] hz_state
);

    localparam int unsigned CNT_W = 3;
    localparam logic [CNT_W-1:0] FLUSH_RELOAD = CNT_W'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_MD_WAIT  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic [CNT_W-1:0] w_flush_cnt_nxt;
    logic             w_raw_ex;
    logic             w_load_use;
    logic             w_data_stall;

    // x0 is hardwired zero, so it never creates a dependency
    function automatic logic raw_match(input logic used, input logic [4:0] rs, input logic [4:0] rd);
        return used && (rs == rd) && (rd != 5'd0);
    endfunction

    assign w_raw_ex   = raw_match(id_rs1_used, id_rs1, ex_rd) || raw_match(id_rs2_used, id_rs2, ex_rd);
    assign w_load_use = ex_mem_read && w_raw_ex;

`ifdef HAZARD_FWD_EN
    logic w_unused_mem;
    assign w_unused_mem = &{1'b0, mem_rd, mem_reg_write};
    assign w_data_stall = w_load_use;
`else
    logic w_raw_mem;
    assign w_raw_mem    = raw_match(id_rs1_used, id_rs1, mem_rd) || raw_match(id_rs2_used, id_rs2, mem_rd);
    assign w_data_stall = w_load_use || (ex_reg_write && w_raw_ex) || (mem_reg_write && w_raw_mem);
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_RUN;
            r_flush_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
        end
    end

    // Priority: redirect > mul/div > data stall; outputs forced low during reset
    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        pc_stall        = 1'b0;
        data_hazard     = 1'b0;
        control_hazard  = 1'b0;
        id_ex_flush     = 1'b0;
        ex_stall        = 1'b0;
        hz_state        = 2'd0;

        if (rst) begin
            hz_state = r_state;
            case (r_state)
                ST_RUN: begin
                    if (ex_branch_taken) begin
                        control_hazard = 1'b1;
                        id_ex_flush    = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            w_state_nxt     = ST_REDIRECT;
                            w_flush_cnt_nxt = FLUSH_RELOAD;
                        end
                    end else if (ex_md_start) begin
                        if (!md_done) begin
                            pc_stall    = 1'b1;
                            data_hazard = 1'b1;
                            ex_stall    = 1'b1;
                            w_state_nxt = ST_MD_WAIT;
                        end
                    end else if (w_data_stall) begin
                        pc_stall    = 1'b1;
                        data_hazard = 1'b1;
                        id_ex_flush = 1'b1;
                    end
                end
                ST_REDIRECT: begin
                    control_hazard = 1'b1;
                    if (ex_branch_taken) begin
                        id_ex_flush     = 1'b1;
                        w_flush_cnt_nxt = FLUSH_RELOAD;
                    end else begin
                        w_flush_cnt_nxt = r_flush_cnt - CNT_W'(1);
                        if (r_flush_cnt <= CNT_W'(1)) begin
                            w_state_nxt     = ST_RUN;
                            w_flush_cnt_nxt = '0;
                        end
                    end
                end
                ST_MD_WAIT: begin
                    if (md_done) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        pc_stall    = 1'b1;
                        data_hazard = 1'b1;
                        ex_stall    = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt     = ST_RUN;
                    w_flush_cnt_nxt = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with FLUSH_CYCLES=3; expectations queued at drive time, checked after settle.
module tb_hazard_ctrl;

    typedef struct packed {
        logic       pc_stall;
        logic       data_hazard;
        logic       control_hazard;
        logic       id_ex_flush;
        logic       ex_stall;
        logic [1:0] hz_state;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd;
    logic       id_rs1_used, id_rs2_used, ex_reg_write, ex_mem_read, mem_reg_write;
    logic       ex_branch_taken, ex_md_start, md_done;
    logic       pc_stall, data_hazard, control_hazard, id_ex_flush, ex_stall;
    logic [1:0] hz_state;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.FLUSH_CYCLES(3)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .ex_branch_taken(ex_branch_taken), .ex_md_start(ex_md_start), .md_done(md_done),
        .pc_stall(pc_stall), .data_hazard(data_hazard), .control_hazard(control_hazard),
        .id_ex_flush(id_ex_flush), .ex_stall(ex_stall), .hz_state(hz_state)
    );

    function automatic exp_t mk(input logic ps, input logic dh, input logic ch,
                                input logic idf, input logic exs, input logic [1:0] st);
        exp_t e;
        e = '{ps, dh, ch, idf, exs, st};
        return e;
    endfunction

    // Start a new cycle: wait for the falling edge, then return inputs to idle
    task automatic cyc();
        @(negedge clk);
        rst = 1'b1;
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        ex_rd = 5'd0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
        mem_rd = 5'd0; mem_reg_write = 1'b0;
        ex_branch_taken = 1'b0; ex_md_start = 1'b0; md_done = 1'b0;
    endtask

    task automatic expect_now(input string tag, input exp_t e);
        exp_t want, got;
        exp_q.push_back(e);
        #1;
        want = exp_q.pop_front();
        got  = '{pc_stall, data_hazard, control_hazard, id_ex_flush, ex_stall, hz_state};
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s: observed ps/dh/ch/idf/exs/st=%b expected %b", tag, got, want);
        end
    endtask

    exp_t NONE, LU_STALL, MD_STALL, MD_WAIT_STALL, BR_RUN, RED, RED_RELOAD, IDLE_RED, IDLE_MD;
    exp_t FWD_STALL;

    initial begin
        NONE          = mk(0, 0, 0, 0, 0, 2'd0);
        LU_STALL      = mk(1, 1, 0, 1, 0, 2'd0);
        MD_STALL      = mk(1, 1, 0, 0, 1, 2'd0);
        MD_WAIT_STALL = mk(1, 1, 0, 0, 1, 2'd2);
        IDLE_MD       = mk(0, 0, 0, 0, 0, 2'd2);
        BR_RUN        = mk(0, 0, 1, 1, 0, 2'd0);
        RED           = mk(0, 0, 1, 0, 0, 2'd1);
        RED_RELOAD    = mk(0, 0, 1, 1, 0, 2'd1);
        IDLE_RED      = mk(0, 0, 0, 0, 0, 2'd1);
`ifdef HAZARD_FWD_EN
        FWD_STALL     = NONE;
`else
        FWD_STALL     = LU_STALL;
`endif

        // Reset, including with a load-use pattern present
        cyc(); rst = 1'b0; expect_now("reset_idle", NONE);
        cyc(); rst = 1'b0; ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_used = 1;
        expect_now("reset_masks_stall", NONE);
        cyc(); expect_now("run_idle", NONE);

        // Load-use: one stall, bubble clears the match
        cyc(); ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_used = 1;
        expect_now("load_use", LU_STALL);
        cyc(); id_rs1 = 5'd5; id_rs1_used = 1; expect_now("load_use_release", NONE);
        cyc(); ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs1_used = 1;
        expect_now("load_use_x0", NONE);
        cyc(); ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5'd9; id_rs2 = 5'd9; id_rs2_used = 0;
        expect_now("load_use_rs2_unused", NONE);
        cyc(); ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5'd9; id_rs2 = 5'd9; id_rs2_used = 1;
        expect_now("load_use_rs2", LU_STALL);

        // Redirect: three control_hazard cycles, bubble only on the first
        cyc(); ex_branch_taken = 1; expect_now("redir_0", BR_RUN);
        cyc(); expect_now("redir_1", RED);
        cyc(); expect_now("redir_2", RED);
        cyc(); expect_now("redir_done", NONE);

        // Branch together with a load-use match: redirect wins
        cyc(); ex_branch_taken = 1; ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_used = 1;
        expect_now("simul_branch_lu", BR_RUN);
        cyc(); ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_used = 1;
        expect_now("redirect_ignores_lu", RED);
        cyc(); expect_now("simul_red_2", RED);
        cyc(); expect_now("simul_done", NONE);

        // Branch inside REDIRECT reloads the counter
        cyc(); ex_branch_taken = 1; expect_now("reload_0", BR_RUN);
        cyc(); ex_branch_taken = 1; expect_now("reload_hit", RED_RELOAD);
        cyc(); expect_now("reload_1", RED);
        cyc(); expect_now("reload_2", RED);
        cyc(); expect_now("reload_done", NONE);

        // Branch and mul/div start together: redirect wins, no wait
        cyc(); ex_branch_taken = 1; ex_md_start = 1; expect_now("br_over_md", BR_RUN);
        cyc(); expect_now("br_over_md_1", RED);
        cyc(); expect_now("br_over_md_2", RED);
        cyc(); expect_now("br_over_md_done", NONE);

        // Mul/div: four stall cycles, done cycle free
        cyc(); ex_md_start = 1; expect_now("md_start", MD_STALL);
        cyc(); expect_now("md_wait_1", MD_WAIT_STALL);
        cyc(); ex_branch_taken = 1; ex_mem_read = 1; ex_rd = 5'd3; id_rs1 = 5'd3; id_rs1_used = 1;
        expect_now("md_wait_ignores", MD_WAIT_STALL);
        cyc(); expect_now("md_wait_3", MD_WAIT_STALL);
        cyc(); md_done = 1; expect_now("md_done", IDLE_MD);
        cyc(); expect_now("md_back_run", NONE);
        cyc(); ex_md_start = 1; md_done = 1; expect_now("md_same_cycle", NONE);
        cyc(); expect_now("md_same_cycle_run", NONE);

        // Non-load RAW vs EX then MEM: stalls only without forwarding
        cyc(); ex_reg_write = 1; ex_rd = 5'd7; id_rs2 = 5'd7; id_rs2_used = 1;
        expect_now("raw_ex", FWD_STALL);
        cyc(); mem_reg_write = 1; mem_rd = 5'd7; id_rs2 = 5'd7; id_rs2_used = 1;
        expect_now("raw_mem", FWD_STALL);
        cyc(); id_rs2 = 5'd7; id_rs2_used = 1; expect_now("raw_release", NONE);
        cyc(); mem_reg_write = 0; mem_rd = 5'd7; id_rs1 = 5'd7; id_rs1_used = 1;
        expect_now("raw_mem_nowrite", NONE);

        // Reset in the middle of MD_WAIT and REDIRECT
        cyc(); ex_md_start = 1; expect_now("rmd_start", MD_STALL);
        cyc(); expect_now("rmd_wait", MD_WAIT_STALL);
        cyc(); rst = 1'b0; expect_now("rmd_reset", NONE);
        cyc(); expect_now("rmd_resume", NONE);
        cyc(); ex_branch_taken = 1; expect_now("rred_start", BR_RUN);
        cyc(); rst = 1'b0; expect_now("rred_reset", NONE);
        cyc(); expect_now("rred_resume", NONE);
        cyc(); ex_mem_read = 1; ex_rd = 5'd4; id_rs1 = 5'd4; id_rs1_used = 1;
        expect_now("post_reset_lu", LU_STALL);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
